// File: rtl/updown_counter_hex.sv
// Up/down counter with load, terminal value and registered hex display.
// Define COUNTER_LZ_BLANK_EN to blank leading-zero digits above digit 0.
module updown_counter_hex #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   up,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  output logic [WIDTH-1:0]       Q,
  output logic                   wrap,
  output logic [7*(WIDTH/4)-1:0] HEX
);

  localparam int DIGITS = WIDTH / 4;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0]    q_q, q_d;
  logic                wrap_q, wrap_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [7*DIGITS-1:0] hex_rst();
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef COUNTER_LZ_BLANK_EN
      r[7*k +: 7] = (k == 0) ? 7'h40 : 7'h7F;
`else
      r[7*k +: 7] = 7'h40;
`endif
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] HEX_RST = hex_rst();

  // Exact compares against MAX so non-power-of-two ranges wrap correctly
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (load_value > MAX) ? MAX : load_value;
    end else if (enable) begin
      if (up) begin
        if (q_q == MAX) begin
          q_d    = ZERO;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + ONE;
        end
      end else begin
        if (q_q == ZERO) begin
          q_d    = MAX;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - ONE;
        end
      end
    end
  end

  always_comb begin
    logic [3:0] nib;
    logic       nz;
    hex_d = '0;
    nz    = 1'b0;
    nib   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = q_q[4*k +: 4];
      nz  = nz | (nib != 4'h0);
`ifdef COUNTER_LZ_BLANK_EN
      hex_d[7*k +: 7] = (k == 0 || nz) ? seg7(nib) : 7'h7F;
`else
      hex_d[7*k +: 7] = seg7(nib);
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      hex_q  <= HEX_RST;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      hex_q  <= hex_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_updown_counter_hex.sv
// Directed bench for updown_counter_hex across four parameter sets.
// Honours COUNTER_LZ_BLANK_EN for the expected display patterns.
module tb_updown_counter_hex;

  logic       clock, reset, enable, up, load;
  logic [7:0] lv;

  logic [7:0]  q0, q2, q3;
  logic [3:0]  q1;
  logic        w0, w1, w2, w3;
  logic [13:0] h0, h2, h3;
  logic [6:0]  h1;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef COUNTER_LZ_BLANK_EN
  localparam logic [6:0] UPZ = 7'h7F;
`else
  localparam logic [6:0] UPZ = 7'h40;
`endif
  localparam logic [13:0] RST8 = {UPZ, 7'h40};

  updown_counter_hex #(.WIDTH(8), .MAX(255)) d0 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(lv), .Q(q0), .wrap(w0), .HEX(h0));

  updown_counter_hex #(.WIDTH(4), .MAX(9)) d1 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(lv[3:0]), .Q(q1), .wrap(w1), .HEX(h1));

  updown_counter_hex #(.WIDTH(8), .MAX(99)) d2 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(lv), .Q(q2), .wrap(w2), .HEX(h2));

  updown_counter_hex #(.WIDTH(8), .MAX(200)) d3 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .load(load), .load_value(lv), .Q(q3), .wrap(w3), .HEX(h3));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_q0", 32'(q0), 0);
    check("rst_w0", 32'(w0), 0);
    check("rst_h0", 32'(h0), 32'(RST8));
    check("rst_h1", 32'(h1), 32'h40);
    check("rst_h2", 32'(h2), 32'(RST8));
    reset = 1'b0;
    enable = 1'b1;

    // count 0..5 on the 8-bit counter
    for (int i = 1; i <= 5; i++) begin
      step();
      check("cnt_q0", 32'(q0), 32'(i));
      check("cnt_w0", 32'(w0), 0);
      check("cnt_h0lo", 32'(h0[6:0]), 32'(seg[i-1]));
      check("cnt_h0hi", 32'(h0[13:7]), 32'(UPZ));
    end

    // MAX=9 up wrap; load wins over enable
    load = 1'b1; lv = 8'd8;
    step();
    check("ld8_q1", 32'(q1), 8);
    check("ld8_w1", 32'(w1), 0);
    load = 1'b0;
    step();
    check("up9_q1", 32'(q1), 9);
    check("up9_w1", 32'(w1), 0);
    step();
    check("wrp_q1", 32'(q1), 0);
    check("wrp_w1", 32'(w1), 1);
    step();
    check("up1_q1", 32'(q1), 1);
    check("up1_w1", 32'(w1), 0);
    check("up1_h1", 32'(h1), 32'(seg[0]));

    // down wrap with MAX=99 and with MAX=255
    load = 1'b1; lv = 8'd1;
    step();
    check("ld1_q2", 32'(q2), 1);
    load = 1'b0; up = 1'b0;
    step();
    check("dn0_q2", 32'(q2), 0);
    check("dn0_w2", 32'(w2), 0);
    check("dn0_q0", 32'(q0), 0);
    step();
    check("dnw_q2", 32'(q2), 99);
    check("dnw_w2", 32'(w2), 1);
    check("dnw_q0", 32'(q0), 255);
    check("dnw_w0", 32'(w0), 1);
    check("dnw_q3", 32'(q3), 200);
    check("dnw_w3", 32'(w3), 1);
    step();
    check("dn98_q2", 32'(q2), 98);
    check("dn98_w2", 32'(w2), 0);
    check("dn98_h2", 32'(h2), 32'({seg[6], seg[3]}));
    enable = 1'b0;
    step();
    check("hold_q2", 32'(q2), 98);
    check("hold_w2", 32'(w2), 0);
    check("hold_h2", 32'(h2), 32'({seg[6], seg[2]}));

    // load clamp, then wrap from MAX
    load = 1'b1; lv = 8'd250; enable = 1'b1; up = 1'b1;
    step();
    check("clp_q3", 32'(q3), 200);
    check("clp_w3", 32'(w3), 0);
    check("clp_q2", 32'(q2), 99);
    check("noclp_q0", 32'(q0), 250);
    load = 1'b0;
    step();
    check("mxw_q3", 32'(q3), 0);
    check("mxw_w3", 32'(w3), 1);
    check("mxw_q2", 32'(q2), 0);
    check("mxw_w2", 32'(w2), 1);
    check("mxu_q0", 32'(q0), 251);

    // asynchronous reset between edges
    load = 1'b1; lv = 8'h36;
    step();
    check("ld36_q0", 32'(q0), 32'h36);
    load = 1'b0;
    step();
    check("cnt37_q0", 32'(q0), 32'h37);
    check("cnt37_h0", 32'(h0), 32'({seg[3], seg[6]}));
    #3 reset = 1'b1;
    #1;
    check("ar_q0", 32'(q0), 0);
    check("ar_w0", 32'(w0), 0);
    check("ar_h0", 32'(h0), 32'(RST8));
    #1 reset = 1'b0;
    enable = 1'b0;
    step();
    check("arh_q0", 32'(q0), 0);
    step();
    check("arh2_q0", 32'(q0), 0);
    check("arh2_h0", 32'(h0), 32'(RST8));

    // direction flip each edge
    load = 1'b1; lv = 8'd5;
    step();
    check("ld5_q0", 32'(q0), 5);
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      step();
      check("flip_q0", 32'(q0), (i % 2 == 0) ? 6 : 5);
      check("flip_w0", 32'(w0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_hex.md
# updown_counter_hex

Parametrised up/down counter with synchronous load, programmable terminal value and a registered multi-digit seven-segment display driver. It generalises the 4-bit counter-plus-display top level to any nibble-multiple width, bidirectional counting and wrap signalling. It drives the board HEX displays directly, one digit per nibble of the count.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; must be a multiple of 4 and at least 4; DIGITS = WIDTH/4.
- MAX, 2**WIDTH-1, terminal count; the valid range is 0..MAX; must satisfy 1 <= MAX <= 2**WIDTH-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable; one step per clock while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value to load.
- Q  output  WIDTH  current count, registered.
- wrap  output  1  one-cycle pulse on the edge where the count wraps.
- HEX  output  7*DIGITS  active-low segments; HEX[7k+6:7k] shows nibble k (k = 0 is least significant); bit 0 = segment a through bit 6 = segment g.

## Operation
- Reset, asynchronous: Q = 0, wrap = 0, HEX = the "0" pattern on every digit (7'b1000000). With blanking enabled, HEX = digit 0 shows "0" and all other digits are blank (7'b1111111).
- Priority per edge: reset > load > enable > hold.
- Load:
  - Q <= load_value if load_value <= MAX, else Q <= MAX (clamp).
  - wrap = 0.
  - enable is ignored on that edge.
- Count up (enable = 1, up = 1):
  - Q < MAX: Q <= Q+1.
  - Q == MAX: Q <= 0 and wrap = 1.
- Count down (enable = 1, up = 0):
  - Q > 0: Q <= Q-1.
  - Q == 0: Q <= MAX and wrap = 1.
- Hold (enable = 0, load = 0): Q is unchanged and wrap = 0.
- wrap is registered. It is high for exactly the one cycle following the wrapping edge, and repeats on every wrap, including consecutive wraps when MAX = 1.
- The direction input is sampled every edge. A direction change takes effect on the same edge without any extra cycle.
- Digit decode: 0-9 and A-F use standard hexadecimal glyphs (b and d in lowercase). Codes for 0-F are 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, active-low, g..a).
- Arithmetic is WIDTH-bit unsigned. The comparisons against MAX must be exact and must not rely on natural overflow, so that non-power-of-two MAX values work.

## Timing
- Q and wrap update on the clock edge that samples the control inputs, i.e. one cycle of latency from the inputs.
- HEX is registered from Q, so it lags Q by one cycle. After reset deassertion, HEX matches Q at every edge delayed by one cycle.
- Reset asserted in the middle of counting clears Q, wrap and HEX immediately, without waiting for a clock. Counting resumes from 0 on the first edge after release when enable = 1.
- load and enable asserted on the same edge: load wins.
- There is no combinational path from any input to any output.

## Configuration
- Macro: COUNTER_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - Any digit k > 0 whose nibble and all higher nibbles are 0 is driven 7'b1111111.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the same registered stage as HEX, so latency is unchanged.
- Undefined: all digits are always displayed, including leading zeros.

## Test plan
- Reset/count: WIDTH = 8, MAX = 255. Assert reset, release, then hold enable = 1 and up = 1 for 5 cycles -> Q = 0,1,2,3,4,5. HEX[6:0] follows one cycle later. HEX[13:7] = 7'b1000000 throughout (7'b1111111 with COUNTER_LZ_BLANK_EN).
- Up wrap with non-power-of-two MAX: WIDTH = 4, MAX = 9. Load 8, then count up 3 cycles -> Q = 9,0,1. wrap is high only in the cycle where Q = 0.
- Down wrap: WIDTH = 8, MAX = 99. Load 1, up = 0, enable for 3 cycles -> Q = 0,99,98. wrap is high only in the cycle where Q = 99. HEX then shows 6,3 (0x63).
- Load clamp and priority: WIDTH = 8, MAX = 200. Set load = 1, load_value = 250, enable = 1 -> Q = 200 and no wrap. On the next edge, with up = 1 -> Q = 0 and wrap = 1.
- Async reset mid-count: while counting at Q = 0x37, assert reset between clock edges -> Q, wrap and HEX clear before the next edge. Hold enable = 0 after release -> Q stays 0.
- Direction flip: at Q = 5, alternate up = 1,0,1,0 with enable = 1 -> Q = 6,5,6,5. wrap stays 0.
